mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/cpu_pkg.sv | 15 +
 rtl/dm_watchdog.sv | 26 ++
 rtl/mem_access_ctrl.sv | 130 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the data-memory access path.
// Timeout support in mem_access_ctrl is enabled by DM_TIMEOUT_EN.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } mac_state_t;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;
  localparam logic [3:0]  WEB_NONE     = 4'hF;

endpackage

// File: rtl/dm_watchdog.sv
// Cycle watchdog: counts enabled cycles, flags the last one
// before the limit so the owner can leave on that edge.
module dm_watchdog (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       clear,
  input  logic [7:0] limit,
  output logic       expire
);

  logic [7:0] count;

  assign expire = enable && (count == limit - 8'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (enable && !expire) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access FSM with pipeline stall.
// Define DM_TIMEOUT_EN to add the WAIT watchdog and dm_err.
module mem_access_ctrl
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = 14,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              EX_MEM_mem_r,
  input  logic              EX_MEM_mem_w,
  input  logic [31:0]       EX_MEM_addr,
  input  logic [31:0]       EX_MEM_wdata,
  input  logic [3:0]        EX_MEM_web,
  output logic              DM_req,
  input  logic              DM_ready,
  output logic [ADDR_W-1:0] DM_addr,
  output logic [31:0]       DM_wdata,
  output logic [3:0]        DM_web,
  input  logic [31:0]       DM_rdata,
  output logic [31:0]       MEM_rdata,
  output logic              MEM_rdata_valid,
`ifdef DM_TIMEOUT_EN
  output logic              dm_err,
`endif
  output logic              EX_MEM_reg_disable_stall
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT);

  mac_state_t state, state_n;
  logic       is_load;
  logic       req_new;
  logic       expire;

  logic unused_addr_bits;
  assign unused_addr_bits =
    ^{EX_MEM_addr[31:ADDR_W+2], EX_MEM_addr[1:0]};

  assign req_new = EX_MEM_mem_r || EX_MEM_mem_w;

`ifdef DM_TIMEOUT_EN
  dm_watchdog u_wdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (state == WAIT),
    .clear  (state != WAIT),
    .limit  (LIMIT),
    .expire (expire)
  );
`else
  logic [7:0] unused_limit;
  assign unused_limit = LIMIT;
  assign expire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    DM_req = 1'b0;
    MEM_rdata_valid = 1'b0;
    EX_MEM_reg_disable_stall = 1'b0;
    unique case (state)
      IDLE: begin
        EX_MEM_reg_disable_stall = req_new;
        if (req_new) state_n = REQ;
      end
      REQ: begin
        DM_req = 1'b1;
        EX_MEM_reg_disable_stall = 1'b1;
        state_n = WAIT;
      end
      WAIT: begin
        EX_MEM_reg_disable_stall = 1'b1;
        if (DM_ready || expire) state_n = DONE;
      end
      DONE: begin
        MEM_rdata_valid = is_load;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // A load wins over a simultaneous store: no byte is written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      DM_addr  <= '0;
      DM_wdata <= 32'd0;
      DM_web   <= WEB_NONE;
      is_load  <= 1'b0;
    end else if (state == IDLE && req_new) begin
      DM_addr  <= EX_MEM_addr[ADDR_W+1:2];
      DM_wdata <= EX_MEM_wdata;
      DM_web   <= EX_MEM_mem_r ? WEB_NONE : EX_MEM_web;
      is_load  <= EX_MEM_mem_r;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      MEM_rdata <= 32'd0;
    end else if (state == WAIT) begin
      if (DM_ready) begin
        if (is_load) MEM_rdata <= DM_rdata;
      end else if (expire) begin
        MEM_rdata <= TIMEOUT_DATA;
      end
    end
  end

`ifdef DM_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dm_err <= 1'b0;
    end else if (state == WAIT && !DM_ready && expire) begin
      dm_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl (vector table,
// load-data scoreboard, reset and back-to-back sequences).
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_r = 1'b0;
  logic        mem_w = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [3:0]  web = 4'hF;
  logic        dm_req;
  logic        dm_ready = 1'b0;
  logic [13:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_web;
  logic [31:0] dm_rdata = 32'd0;
  logic [31:0] mem_rdata;
  logic        valid;
  logic        stall;
`ifdef DM_TIMEOUT_EN
  logic        dm_err;
`endif

  int passed = 0;
  int total = 0;
  logic [31:0] sb[$];
  logic [31:0] last_load = 32'd0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_W(14), .TIMEOUT(4)) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .EX_MEM_mem_r             (mem_r),
    .EX_MEM_mem_w             (mem_w),
    .EX_MEM_addr              (addr),
    .EX_MEM_wdata             (wdata),
    .EX_MEM_web               (web),
    .DM_req                   (dm_req),
    .DM_ready                 (dm_ready),
    .DM_addr                  (dm_addr),
    .DM_wdata                 (dm_wdata),
    .DM_web                   (dm_web),
    .DM_rdata                 (dm_rdata),
    .MEM_rdata                (mem_rdata),
    .MEM_rdata_valid          (valid),
`ifdef DM_TIMEOUT_EN
    .dm_err                   (dm_err),
`endif
    .EX_MEM_reg_disable_stall (stall)
  );

  typedef struct {
    logic        r;
    logic        w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  web;
    int          delay;
    logic [31:0] rdata;
    logic [13:0] e_addr;
    logic [3:0]  e_web;
  } vec_t;

  vec_t vecs[6];
  vec_t va, vb;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s actual=%h required=%h",
               name, act, exp);
    else
      passed++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        chk("sb_rdata", mem_rdata, sb.pop_front());
      end
    end
  end

  // Leaves the DUT in DONE with the request still driven.
  task automatic access(input vec_t v, input bit from_done);
    mem_r = v.r;
    mem_w = v.w;
    addr  = v.addr;
    wdata = v.wdata;
    web   = v.web;
    if (v.r) sb.push_back(v.rdata);
    #1;
    if (from_done) begin
      chk("done_stall_pending", 32'(stall), 32'd0);
      chk("done_no_req", 32'(dm_req), 32'd0);
      step();
    end
    chk("idle_stall", 32'(stall), 32'd1);
    chk("idle_no_req", 32'(dm_req), 32'd0);
    step();
    chk("req_pulse", 32'(dm_req), 32'd1);
    chk("req_stall", 32'(stall), 32'd1);
    chk("dm_addr", 32'(dm_addr), 32'(v.e_addr));
    chk("dm_web", 32'(dm_web), 32'(v.e_web));
    if (!v.r) chk("dm_wdata", dm_wdata, v.wdata);
    step();
    for (int i = 0; i < v.delay; i++) begin
      chk("wait_no_req", 32'(dm_req), 32'd0);
      chk("wait_stall", 32'(stall), 32'd1);
      step();
    end
    dm_ready = 1'b1;
    dm_rdata = v.rdata;
    #1;
    chk("ready_stall", 32'(stall), 32'd1);
    chk("ready_no_req", 32'(dm_req), 32'd0);
    if (!v.r) begin
      chk("wdata_stable", dm_wdata, v.wdata);
      chk("web_stable", 32'(dm_web), 32'(v.e_web));
    end
    step();
    dm_ready = 1'b0;
    dm_rdata = $urandom;
    #1;
    chk("done_stall", 32'(stall), 32'd0);
    chk("done_valid", 32'(valid), 32'(v.r));
    if (v.r) last_load = v.rdata;
    else chk("rdata_hold", mem_rdata, last_load);
  endtask

  task automatic end_access();
    mem_r = 1'b0;
    mem_w = 1'b0;
    step();
    chk("idle_after_stall", 32'(stall), 32'd0);
    chk("idle_after_req", 32'(dm_req), 32'd0);
    chk("idle_after_valid", 32'(valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=done");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'hF,
                0, 32'h1234_5678, 14'h0004, 4'hF};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D,
                4'b1100, 5, 32'h0, 14'h0008, 4'b1100};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0044, 32'h1111_1111,
                4'h0, 1, 32'hA5A5_5A5A, 14'h0011, 4'hF};
    vecs[3] = '{1'b1, 1'b0, 32'h0001_0008, 32'h0, 4'hF,
                2, 32'h0BAD_F00D, 14'h0002, 4'hF};
    vecs[4] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0, 4'h0,
                0, 32'h0, 14'h3FFF, 4'h0};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_3FFC, 32'h0, 4'hF,
                3, 32'hFFFF_FFFF, 14'h0FFF, 4'hF};

    #12;
    chk("rst_req", 32'(dm_req), 32'd0);
    chk("rst_addr", 32'(dm_addr), 32'd0);
    chk("rst_wdata", dm_wdata, 32'd0);
    chk("rst_web", 32'(dm_web), 32'hF);
    chk("rst_rdata", mem_rdata, 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
`ifdef DM_TIMEOUT_EN
    chk("rst_err", 32'(dm_err), 32'd0);
`endif
    step();
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 6; i++) begin
      access(vecs[i], 1'b0);
      end_access();
    end

    va = '{1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'hF,
           0, 32'h0101_0101, 14'h0040, 4'hF};
    vb = '{1'b1, 1'b0, 32'h0000_0104, 32'h0, 4'hF,
           1, 32'h0202_0202, 14'h0041, 4'hF};
    access(va, 1'b0);
    access(vb, 1'b1);
    end_access();

    mem_r = 1'b1;
    addr = 32'h0000_0040;
    step();
    step();
    step();
    rst_n = 1'b0;
    mem_r = 1'b0;
    #1;
    chk("abort_stall", 32'(stall), 32'd0);
    chk("abort_req", 32'(dm_req), 32'd0);
    chk("abort_addr", 32'(dm_addr), 32'd0);
    chk("abort_web", 32'(dm_web), 32'hF);
    chk("abort_rdata", mem_rdata, 32'd0);
    step();
    rst_n = 1'b1;
    last_load = 32'd0;
    dm_ready = 1'b1;
    dm_rdata = 32'h5555_AAAA;
    step();
    dm_ready = 1'b0;
    #1;
    chk("late_ready_stall", 32'(stall), 32'd0);
    chk("late_ready_req", 32'(dm_req), 32'd0);
    chk("late_ready_valid", 32'(valid), 32'd0);
    step();
    chk("late_ready_valid2", 32'(valid), 32'd0);
    chk("late_ready_rdata", mem_rdata, 32'd0);

`ifdef DM_TIMEOUT_EN
    begin
      int n;
      mem_r = 1'b1;
      addr = 32'h0000_0080;
      sb.push_back(32'hDEAD_BEEF);
      step();
      step();
      n = 0;
      while (stall && n < 20) begin
        n++;
        step();
      end
      chk("to_wait_cycles", 32'(n), 32'd4);
      chk("to_valid", 32'(valid), 32'd1);
      chk("to_rdata", mem_rdata, 32'hDEAD_BEEF);
      chk("to_err", 32'(dm_err), 32'd1);
      end_access();
      repeat (3) step();
      chk("to_err_sticky", 32'(dm_err), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("to_err_clear", 32'(dm_err), 32'd0);
      step();
      rst_n = 1'b1;
      step();
    end
`else
    va = '{1'b1, 1'b0, 32'h0000_0080, 32'h0, 4'hF,
           30, 32'h7777_0001, 14'h0020, 4'hF};
    access(va, 1'b0);
    end_access();
`endif

    repeat (2) step();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
